// File: rtl/read_source_fsm_if.sv
// rtl/read_source_fsm_if.sv - AXI read address/data channels between the read source and source memory
interface read_source_fsm_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/read_source_fsm.sv
// rtl/read_source_fsm.sv - DMA read source: splits a descriptor into AXI read bursts feeding the data FIFO
module read_source_fsm #(
  parameter int DATA_W      = 512,
  parameter int ADDR_W      = 64,
  parameter int LENGTH_W    = 24,
  parameter int AXI_LEN_W   = 4,
  parameter int FIFO_CNT_W  = 10,
  parameter int PERF_CNTR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic                   desc_go,
  input  logic [ADDR_W-1:0]      desc_src_addr,
  input  logic [LENGTH_W-1:0]    desc_length,
  read_source_fsm_if.master      axi,
  input  logic [FIFO_CNT_W-1:0]  fifo_free,
  output logic                   fifo_wr_en,
  output logic [DATA_W-1:0]      fifo_wr_data,
  input  logic                   clear_error,
  output logic                   rd_fsm_done,
  output logic                   rd_err,
  output logic                   busy,
  output logic [3:0]             rd_state,
  output logic [PERF_CNTR_W-1:0] clk_cnt,
  output logic [PERF_CNTR_W-1:0] valid_cnt
);
  localparam int BYTES = DATA_W / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int MAXB  = 2 ** AXI_LEN_W;
  localparam int BW    = AXI_LEN_W + 1;
  localparam int RW    = FIFO_CNT_W + 1;
  localparam int CW    = ((RW > BW) ? RW : BW) + 1;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    DRAIN = 4'b0100,
    ERROR = 4'b1000
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LENGTH_W-1:0] rem, total, rcvd;
  logic [RW-1:0]     reserved;
  logic              arvalid;
  logic [7:0]        arlen;

  logic [BW-1:0]     beats;
  logic [RW-1:0]     rsv_sum;
  logic              active, accept, ar_hs, r_beat, r_err, fits, last_beat;

  assign beats     = (rem > LENGTH_W'(MAXB)) ? BW'(MAXB) : BW'(rem);
  assign active    = (state == ISSUE) || (state == DRAIN);
  assign accept    = (state == IDLE) && desc_valid && desc_go && !reset;
  assign ar_hs     = arvalid && axi.arready;
  assign r_beat    = axi.rvalid;
  assign r_err     = active && r_beat && axi.rresp[1];
  // Space for the whole burst must already be free on top of what earlier bursts still owe the FIFO.
  assign fits      = CW'(fifo_free) >= (CW'(reserved) + CW'(beats));
  assign rsv_sum   = reserved + (ar_hs ? RW'(beats) : RW'(0));
  assign last_beat = ({1'b0, rcvd} + {{LENGTH_W{1'b0}}, r_beat}) == {1'b0, total};

  assign desc_ready   = accept;
  assign fifo_wr_en   = r_beat && active;
  assign fifo_wr_data = axi.rdata;
  assign axi.arvalid  = arvalid;
  assign axi.araddr   = addr;
  assign axi.arlen    = arlen;
  assign axi.arsize   = 3'(SIZE);
  assign axi.arburst  = 2'b01;
  assign axi.rready   = 1'b1;
  assign rd_err       = (state == ERROR);
  assign busy         = active;
  assign rd_state     = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      rem         <= '0;
      total       <= '0;
      rcvd        <= '0;
      reserved    <= '0;
      arvalid     <= 1'b0;
      arlen       <= '0;
      rd_fsm_done <= 1'b0;
      clk_cnt     <= '0;
      valid_cnt   <= '0;
    end else begin
      rd_fsm_done <= 1'b0;
      // Floor at zero so stray beats from an abandoned transfer cannot wrap the reservation.
      reserved <= (r_beat && rsv_sum != '0) ? rsv_sum - RW'(1) : rsv_sum;
      if (active) begin
        clk_cnt <= (&clk_cnt) ? clk_cnt : clk_cnt + PERF_CNTR_W'(1);
        if (r_beat) begin
          rcvd      <= rcvd + LENGTH_W'(1);
          valid_cnt <= (&valid_cnt) ? valid_cnt : valid_cnt + PERF_CNTR_W'(1);
        end
      end
      case (state)
        IDLE: begin
          if (accept) begin
            addr      <= desc_src_addr;
            rem       <= desc_length;
            total     <= desc_length;
            rcvd      <= '0;
            reserved  <= '0;
            clk_cnt   <= '0;
            valid_cnt <= '0;
            if (desc_length == '0) rd_fsm_done <= 1'b1;
            else state <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_err) begin
            state   <= ERROR;
            arvalid <= 1'b0;
          end else if (arvalid) begin
            if (axi.arready) begin
              arvalid <= 1'b0;
              addr    <= addr + (ADDR_W'(beats) << SIZE);
              rem     <= rem - LENGTH_W'(beats);
              if (rem == LENGTH_W'(beats)) state <= DRAIN;
            end
          end else if (fits) begin
            arvalid <= 1'b1;
            arlen   <= 8'(beats - BW'(1));
          end
        end
        DRAIN: begin
          if (r_err) begin
            state <= ERROR;
          end else if (last_beat) begin
            state       <= IDLE;
            rd_fsm_done <= 1'b1;
          end
        end
        ERROR: begin
          if (clear_error) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_read_source_fsm.sv
// tb/tb_read_source_fsm.sv - self-checking bench for read_source_fsm with a burst-list reference model
module tb_read_source_fsm;
  logic         clk = 1'b0;
  logic         reset;
  logic         desc_valid, desc_ready, desc_go;
  logic [63:0]  desc_src_addr;
  logic [23:0]  desc_length;
  logic [9:0]   fifo_free;
  logic         fifo_wr_en;
  logic [511:0] fifo_wr_data;
  logic         clear_error;
  logic         rd_fsm_done, rd_err, busy;
  logic [3:0]   rd_state;
  logic [31:0]  clk_cnt, valid_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  read_source_fsm_if #(.DATA_W(512), .ADDR_W(64)) axi ();

  read_source_fsm dut (
    .clk(clk), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_go(desc_go),
    .desc_src_addr(desc_src_addr), .desc_length(desc_length),
    .axi(axi),
    .fifo_free(fifo_free), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .clear_error(clear_error), .rd_fsm_done(rd_fsm_done), .rd_err(rd_err),
    .busy(busy), .rd_state(rd_state), .clk_cnt(clk_cnt), .valid_cnt(valid_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] v;
    v = {$urandom, $urandom};
    v[5:0] = '0;
    return v;
  endfunction

  task automatic accept_desc(input logic [63:0] a, input int len, input string tag);
    desc_valid = 1'b1;
    desc_go = 1'b1;
    desc_src_addr = a;
    desc_length = 24'(len);
    @(negedge clk);
    check(tag, desc_ready, 1);
  endtask

  // mode: 0 arready high, 1 random, 2 low for 5 waiting cycles, 3 only the first AR accepted
  task automatic run_desc(input logic [63:0] a, input int len, input int mode, input int err_beat);
    logic [63:0] exp_addr[$];
    int          exp_len[$];
    logic [63:0] x, pa;
    logic [7:0]  pl;
    logic        err_hit, pv, pr;
    int r, b, pend, sent, ar_cnt, ar_after_err, done_cnt, spurious, t0, tl, td, ar_wait, budget;
    x = a;
    r = len;
    while (r > 0) begin
      b = (r > 16) ? 16 : r;
      exp_addr.push_back(x);
      exp_len.push_back(b - 1);
      x = x + 64'(b * 64);
      r = r - b;
    end
    pend = 0; sent = 0; ar_cnt = 0; ar_after_err = 0; done_cnt = 0; spurious = 0;
    tl = -1; td = -1; ar_wait = 0; err_hit = 1'b0; pv = 1'b0; pr = 1'b0; pa = '0; pl = '0;
    accept_desc(a, len, "desc_ready");
    t0 = cyc;
    tick();
    desc_valid = 1'b0;
    desc_go = 1'b0;
    budget = 3000;
    while (budget > 0) begin
      budget--;
      case (mode)
        0: axi.arready = 1'b1;
        1: axi.arready = 1'($urandom_range(0, 1));
        2: axi.arready = (ar_wait >= 5);
        default: axi.arready = (ar_cnt == 0);
      endcase
      axi.rvalid = (pend > 0) && ($urandom_range(0, 3) != 0);
      axi.rdata = '0;
      axi.rresp = 2'b00;
      if (axi.rvalid) begin
        axi.rdata = rand_data();
        axi.rresp = (sent == err_beat) ? 2'b10 : 2'($urandom_range(0, 1));
        pend--;
        sent++;
      end
      @(negedge clk);
      if (pv && !pr && err_beat < 0) begin
        check("arvalid_hold", axi.arvalid, 1);
        check("araddr_hold", axi.araddr, pa);
        check("arlen_hold", axi.arlen, pl);
      end
      if (axi.arvalid && !axi.arready) ar_wait++;
      if (axi.arvalid && axi.arready) begin
        if (err_hit) ar_after_err++;
        else if (ar_cnt < exp_addr.size()) begin
          check("ar_addr", axi.araddr, exp_addr[ar_cnt]);
          check("ar_len", axi.arlen, exp_len[ar_cnt]);
          pend += exp_len[ar_cnt] + 1;
        end else check("extra_ar", ar_cnt, exp_addr.size());
        ar_cnt++;
      end
      if (axi.rvalid) begin
        check("wr_en", fifo_wr_en, !err_hit);
        if (!err_hit) check("wr_data", fifo_wr_data, axi.rdata);
        if (sent == len) tl = cyc;
      end else if (fifo_wr_en) spurious++;
      if (rd_fsm_done) begin
        done_cnt++;
        td = cyc;
      end
      if (axi.rvalid && axi.rresp[1]) err_hit = 1'b1;
      pv = axi.arvalid; pr = axi.arready; pa = axi.araddr; pl = axi.arlen;
      tick();
      if (err_beat < 0 && done_cnt > 0) break;
      if (err_beat >= 0 && err_hit && pend == 0) break;
    end
    axi.rvalid = 1'b0;
    axi.arready = 1'b0;
    check("timeout", budget > 0, 1);
    check("spurious_wr", spurious, 0);
    if (err_beat < 0) begin
      check("ar_count", ar_cnt, exp_addr.size());
      check("done_count", done_cnt, 1);
      check("done_timing", td, tl + 1);
      check("valid_cnt", valid_cnt, len);
      check("clk_cnt", clk_cnt, tl - t0);
      check("state_idle", rd_state, 4'b0001);
      check("busy_idle", busy, 0);
    end else begin
      check("err_flag", rd_err, 1);
      check("err_state", rd_state, 4'b1000);
      check("err_busy", busy, 0);
      check("err_arvalid", axi.arvalid, 0);
      check("err_no_new_ar", ar_after_err, 0);
      check("err_no_done", done_cnt, 0);
    end
  endtask

  initial begin
    logic [63:0]  a;
    logic [511:0] d;
    int hi, hs, budget;
    reset = 1'b1; desc_valid = 1'b0; desc_go = 1'b0; desc_src_addr = '0; desc_length = '0;
    fifo_free = 10'd512; clear_error = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    repeat (3) tick();
    @(negedge clk);
    check("rst_state", rd_state, 4'b0001);
    check("rst_rready", axi.rready, 1);
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_araddr", axi.araddr, 0);
    check("rst_arlen", axi.arlen, 0);
    check("rst_arsize", axi.arsize, 6);
    check("rst_arburst", axi.arburst, 1);
    check("rst_done", rd_fsm_done, 0);
    check("rst_err", rd_err, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_clk_cnt", clk_cnt, 0);
    check("rst_valid_cnt", valid_cnt, 0);
    tick();
    reset = 1'b0;

    run_desc(rand_addr(), 40, 0, -1);

    // FIFO space gating: 10 free slots cannot hold a 16-beat burst
    a = rand_addr();
    fifo_free = 10'd10;
    accept_desc(a, 16, "ff_desc_ready");
    tick();
    desc_valid = 1'b0; desc_go = 1'b0;
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (axi.arvalid) hi++;
      tick();
    end
    check("ff_blocked", hi, 0);
    fifo_free = 10'd16;
    @(negedge clk);
    check("ff_arvalid_same", axi.arvalid, 0);
    tick();
    @(negedge clk);
    check("ff_arvalid_next", axi.arvalid, 1);
    check("ff_arlen", axi.arlen, 15);
    check("ff_araddr", axi.araddr, a);
    tick();
    axi.arready = 1'b1;
    @(negedge clk);
    check("ff_handshake", axi.arvalid, 1);
    tick();
    axi.arready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      axi.rvalid = 1'b1;
      d = rand_data();
      axi.rdata = d;
      axi.rresp = 2'b00;
      @(negedge clk);
      check("ff_wr_en", fifo_wr_en, 1);
      check("ff_wr_data", fifo_wr_data, d);
      tick();
    end
    axi.rvalid = 1'b0;
    @(negedge clk);
    check("ff_done", rd_fsm_done, 1);
    tick();
    fifo_free = 10'd512;

    run_desc(rand_addr(), 16, 2, -1);

    run_desc(rand_addr(), 32, 3, 2);
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    check("clr_state", rd_state, 4'b0001);
    check("clr_err", rd_err, 0);

    accept_desc(rand_addr(), 0, "z_desc_ready");
    check("z_done_early", rd_fsm_done, 0);
    tick();
    desc_valid = 1'b0; desc_go = 1'b0;
    @(negedge clk);
    check("z_done", rd_fsm_done, 1);
    check("z_arvalid", axi.arvalid, 0);
    check("z_state", rd_state, 4'b0001);
    check("z_valid_cnt", valid_cnt, 0);
    check("z_clk_cnt", clk_cnt, 0);
    tick();
    @(negedge clk);
    check("z_done_pulse", rd_fsm_done, 0);
    check("z_arvalid2", axi.arvalid, 0);
    tick();

    run_desc(64'hFFFF_FFFF_FFFF_FC00, 40, 1, -1);
    for (int k = 0; k < 8; k++) run_desc(rand_addr(), $urandom_range(1, 70), 1, -1);

    // reset in the middle of a burst
    accept_desc(rand_addr(), 16, "rst_desc_ready");
    tick();
    desc_valid = 1'b0; desc_go = 1'b0;
    axi.arready = 1'b1;
    hs = 0;
    budget = 20;
    while (hs == 0 && budget > 0) begin
      budget--;
      @(negedge clk);
      if (axi.arvalid && axi.arready) hs = 1;
      tick();
    end
    check("rst_ar_issued", hs, 1);
    axi.arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      axi.rvalid = 1'b1;
      axi.rdata = rand_data();
      axi.rresp = 2'b00;
      @(negedge clk);
      check("rst_pre_wr_en", fifo_wr_en, 1);
      tick();
    end
    axi.rvalid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_pre_valid_cnt", valid_cnt, 8);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      axi.rvalid = 1'b1;
      axi.rdata = rand_data();
      @(negedge clk);
      if (i == 0) begin
        check("rst_mid_state", rd_state, 4'b0001);
        check("rst_mid_arvalid", axi.arvalid, 0);
        check("rst_mid_clk_cnt", clk_cnt, 0);
        check("rst_mid_busy", busy, 0);
      end
      check("rst_stale_wr_en", fifo_wr_en, 0);
      tick();
    end
    axi.rvalid = 1'b0;
    check("rst_mid_valid_cnt", valid_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
